divider_seq_n: RTL

Sequential unsigned restoring divider that time-multiplexes a single subtractor_n instance, producing one quotient bit per clock. It is the controller that sequences the subtractor datapath for mantissa division (default 24-bit) in the PE arithmetic path. Start/done handshake toward the issuing unit; results stay stable until the next accepted start.

---
 rtl/div_pkg.sv | 17 +
 rtl/subtractor_n.sv | 13 +
 rtl/divider_seq_n.sv | 125 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

  localparam int unsigned DIV_NB_BIT_DEF = 24;

  // Width of the iteration counter, which must be able to hold the value nb_bit.
  function automatic int unsigned div_cnt_w(input int unsigned nb_bit);
    return $clog2(nb_bit + 1);
  endfunction

endpackage

// File: rtl/subtractor_n.sv
// Unsigned N-bit subtractor; borrow_o is set when a_i < b_i.
module subtractor_n #(
  parameter int unsigned nb_bit = 8
) (
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  output logic [nb_bit-1:0] diff_o,
  output logic              borrow_o
);

  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/divider_seq_n.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a shared subtractor.
module divider_seq_n
  import div_pkg::*;
#(
  parameter int unsigned nb_bit = DIV_NB_BIT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [nb_bit-1:0] dividend_i,
  input  logic [nb_bit-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [nb_bit-1:0] quotient_o,
  output logic [nb_bit-1:0] remainder_o,
  output logic              div_by_zero_o
);

  localparam int unsigned CntW = div_cnt_w(nb_bit);

  div_state_e        state_q, state_d;
  logic [nb_bit-1:0] rem_q, rem_d;
  logic [nb_bit-1:0] q_q, q_d;
  logic [nb_bit-1:0] d_q, d_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [nb_bit-1:0] quotient_q, quotient_d;
  logic [nb_bit-1:0] remainder_q, remainder_d;
  logic              dbz_q, dbz_d;

  logic [nb_bit:0]   trial;
  logic [nb_bit:0]   diff;
  logic              borrow;
  logic              unused_diff_msb;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign trial = {rem_q, q_q[nb_bit-1]};

  subtractor_n #(
    .nb_bit(nb_bit + 1)
  ) u_sub (
    .a_i     (trial),
    .b_i     ({1'b0, d_q}),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

  // Without a borrow the difference is below the divisor, so its MSB is always zero.
  assign unused_diff_msb = diff[nb_bit];

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        if (start_i) begin
          d_d     = divisor_i;
          q_d     = dividend_i;
          rem_d   = '0;
          cnt_d   = CntW'(nb_bit);
          dbz_d   = 1'b0;
          state_d = DIV_RUN;
          if (divisor_i == '0) begin
            state_d     = DIV_DONE;
            quotient_d  = '1;
            remainder_d = dividend_i;
            dbz_d       = 1'b1;
          end
        end
      end
      DIV_RUN: begin
        if (!borrow) begin
          rem_d = diff[nb_bit-1:0];
          q_d   = {q_q[nb_bit-2:0], 1'b1};
        end else begin
          rem_d = trial[nb_bit-1:0];
          q_d   = {q_q[nb_bit-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d     = DIV_DONE;
          quotient_d  = q_d;
          remainder_d = rem_d;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= DIV_IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy_o        = (state_q == DIV_RUN);
  assign done_o        = (state_q == DIV_DONE);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;

endmodule
